mips_hazard_unit: RTL and testbench
===================================

# mips_hazard_unit

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It keeps a registered shadow of the destination register, write-enable and load flag for each in-flight instruction. From that shadow it drives:
- EX operand forwarding selects,
- an ID-stage write-back bypass,
- a one-cycle load-use stall,
- branch flushes.

It also keeps saturating stall and flush counters. It sits beside the pipeline buffers and gates their enables and clears; it carries no data.

## Interface
- AW, 5: register address width; register 0 is hard-wired zero.
- BR_STAGE, 3: stage where a taken branch resolves; 2 = EX, 3 = MEM (only legal values).
- CNT_W, 16: width of each performance counter.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i, id_rt_i  in  AW  source registers of the ID instruction
- id_use_rs_i, id_use_rt_i  in  1  ID instruction actually reads rs / rt
- id_dst_i  in  AW  destination register, after the RegDst mux
- id_regwrite_i  in  1  ID instruction writes the register file
- id_memread_i  in  1  ID instruction is a load
- br_taken_i  in  1  branch in stage BR_STAGE is taken this cycle
- fwd_a_o, fwd_b_o  out  2  EX operand select: 00 ID/EX value, 10 EX/MEM ALU result, 01 MEM/WB write data
- id_byp_a_o, id_byp_b_o  out  1  replace the register-file read in ID with the WB data
- stall_o  out  1  hold PC and IF/ID, insert a bubble into ID/EX
- flush_o  out  3  bit0 clear IF/ID, bit1 clear ID/EX, bit2 clear EX/MEM
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

## Operation
- Shadow slots: EX, MEM, WB.
  - Each slot holds {valid, dst, regwrite, memread}.
  - The EX slot also holds {rs, rt, use_rs, use_rt}.
- Each clock edge: WB←MEM, MEM←EX, EX←{ID inputs qualified by id_valid_i}.
- On stall: EX←bubble (valid=0); MEM and WB still advance.
- "Writer" means a slot with valid & regwrite & dst≠0.
- Forwarding for EX operand A (B is identical with rt):
  - 10 if the MEM slot is a writer and its dst equals EX.rs and use_rs is set;
  - otherwise 01 if the WB slot matches under the same conditions;
  - otherwise 00.
  - MEM has priority over WB. A source of 0 always gives 00.
- ID bypass: id_byp_a_o = WB slot is a writer & dst==id_rs_i & id_use_rs_i & id_valid_i. id_byp_b_o uses rt the same way.
- Load-use stall: stall_o = EX slot valid & memread & regwrite & dst≠0 & id_valid_i & ((id_use_rs_i & dst==id_rs_i) | (id_use_rt_i & dst==id_rt_i)).
  - The stall lasts exactly one cycle, because the EX slot becomes a bubble.
- Flush when br_taken_i:
  - BR_STAGE=3: flush_o=111; the EX and MEM slots load bubbles at the edge.
  - BR_STAGE=2: flush_o=011; the EX slot loads a bubble.
- Branch taken and load-use stall in the same cycle: flush wins.
  - stall_o is forced to 0.
  - Only flush_cnt increments.
- Counters:
  - stall_cnt +1 on each cycle stall_o=1.
  - flush_cnt +1 on each cycle br_taken_i=1.
  - Both hold at all-ones.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - all slots invalid and all fields 0;
  - counters 0;
  - all outputs therefore 0 (fwd 00, no stall, no flush, no bypass).
- fwd_*, id_byp_*, stall_o and flush_o are combinational from the registered shadow and the current-cycle inputs. They take effect in the same cycle, with no added latency.
- Shadow and counters update only on the rising edge of clk.
- br_taken_i must be a clean single-cycle pulse per branch. The block does not latch it.
- Reset mid-stall or mid-flush: outputs drop to 0 immediately, with no residual bubble.
- Counter wrap is forbidden; saturation is required.

## Structure
- Package mips_pipe_pkg holds:
  - the fwd_sel_t enum (FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01);
  - the slot struct type;
  - FLUSH_IFID/IDEX/EXMEM bit indices.
- One sub-module, sat_counter (parameter CNT_W, ports clk, rst_n, inc, count), is instantiated twice.
- Comparison logic stays inline.

## Test plan
- Back-to-back dependency: add $3←$1,$2 then sub $4←$3,$5 → in the cycle sub is in EX, fwd_a_o=10, stall_o=0. Repeat with one NOP between the two → fwd_a_o=01.
- Load-use: lw $8 then add $9←$8,$8 → stall_o=1 for exactly one cycle and stall_cnt_o=1. In the following cycle, with add in EX, fwd_a_o=fwd_b_o=01.
- Register 0 and MEM/WB priority:
  - any writer to $0 → fwd stays 00 and no stall occurs;
  - MEM and WB both write $3 → fwd=10.
- Branch flush: BR_STAGE=3, br_taken_i pulse → flush_o=111 for one cycle and flush_cnt_o=1; the next 2 cycles give fwd=00 even though the squashed instructions wrote matching registers. With BR_STAGE=2 → flush_o=011.
- Simultaneous branch and load-use plus reset:
  - both conditions in one cycle → stall_o=0, flush_o set, stall_cnt unchanged;
  - assert rst_n=0 mid-sequence → all outputs 0 before the next edge.
- Saturation: CNT_W=4, 20 consecutive stall cycles → stall_cnt_o=15 and it holds there.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared types, constants and helpers for the MIPS hazard unit
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_t;

    // Shadow register fields are stored at this width; narrower AW values are
    // zero-extended on entry so all comparisons happen at one width.
    localparam int SLOT_AW = 8;

    localparam int FLUSH_IFID  = 0;
    localparam int FLUSH_IDEX  = 1;
    localparam int FLUSH_EXMEM = 2;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memread;
        logic [SLOT_AW-1:0] dst;
    } slot_t;

    typedef struct packed {
        slot_t              ctl;
        logic               use_rs;
        logic               use_rt;
        logic [SLOT_AW-1:0] rs;
        logic [SLOT_AW-1:0] rt;
    } ex_slot_t;

    // A slot whose result will land in a real (non-zero) register.
    function automatic logic is_writer(slot_t s);
        return s.valid & s.regwrite & (s.dst != '0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
// Ports: clk, rst_n (async active-low), inc (count enable), count (value, holds at all-ones)
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mips_hazard_unit.sv
// rtl/mips_hazard_unit.sv - forwarding, load-use stall and branch flush control for a 5-stage MIPS pipe
// Inputs : clk, rst_n, ID-stage instruction fields (id_*_i), br_taken_i
// Outputs: fwd_a_o/fwd_b_o (EX operand select), id_byp_a_o/id_byp_b_o (WB->ID bypass),
//          stall_o, flush_o[2:0] (IF/ID, ID/EX, EX/MEM clears), stall_cnt_o/flush_cnt_o
module mips_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int AW       = 5,
    parameter int BR_STAGE = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [AW-1:0]    id_rs_i,
    input  logic [AW-1:0]    id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [AW-1:0]    id_dst_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             br_taken_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             id_byp_a_o,
    output logic             id_byp_b_o,
    output logic             stall_o,
    output logic [2:0]       flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    ex_slot_t ex_q,  ex_d;
    slot_t    mem_q, mem_d;
    slot_t    wb_q,  wb_d;

    logic [SLOT_AW-1:0] id_rs_w;
    logic [SLOT_AW-1:0] id_rt_w;
    logic               load_use;
    logic               br_w;
    fwd_sel_t           fwd_a, fwd_b;

    assign id_rs_w = SLOT_AW'(id_rs_i);
    assign id_rt_w = SLOT_AW'(id_rt_i);

    // Gated by reset so a flush pulse never reaches the pipe buffers while in reset.
    assign br_w = br_taken_i & rst_n;

    // EX operand forwarding; MEM is younger than WB so it wins.
    always_comb begin
        fwd_a = FWD_REG;
        if (ex_q.use_rs && is_writer(mem_q) && (mem_q.dst == ex_q.rs)) begin
            fwd_a = FWD_MEM;
        end else if (ex_q.use_rs && is_writer(wb_q) && (wb_q.dst == ex_q.rs)) begin
            fwd_a = FWD_WB;
        end
        fwd_b = FWD_REG;
        if (ex_q.use_rt && is_writer(mem_q) && (mem_q.dst == ex_q.rt)) begin
            fwd_b = FWD_MEM;
        end else if (ex_q.use_rt && is_writer(wb_q) && (wb_q.dst == ex_q.rt)) begin
            fwd_b = FWD_WB;
        end
    end

    assign fwd_a_o = fwd_a;
    assign fwd_b_o = fwd_b;

    assign id_byp_a_o = is_writer(wb_q) && (wb_q.dst == id_rs_w) && id_use_rs_i && id_valid_i;
    assign id_byp_b_o = is_writer(wb_q) && (wb_q.dst == id_rt_w) && id_use_rt_i && id_valid_i;

    assign load_use = is_writer(ex_q.ctl) && ex_q.ctl.memread && id_valid_i &&
                      ((id_use_rs_i && (ex_q.ctl.dst == id_rs_w)) ||
                       (id_use_rt_i && (ex_q.ctl.dst == id_rt_w)));

    // A taken branch squashes the dependent instruction anyway, so the stall is dropped.
    assign stall_o = load_use & ~br_w;

    always_comb begin
        flush_o = 3'b000;
        if (br_w) begin
            flush_o[FLUSH_IFID] = 1'b1;
            flush_o[FLUSH_IDEX] = 1'b1;
            if (BR_STAGE == 3) begin
                flush_o[FLUSH_EXMEM] = 1'b1;
            end
        end
    end

    // Shadow advance: a stall or flush turns the incoming EX entry into a bubble.
    always_comb begin
        ex_d = '0;
        if (id_valid_i && !br_w && !load_use) begin
            ex_d.ctl.valid    = 1'b1;
            ex_d.ctl.regwrite = id_regwrite_i;
            ex_d.ctl.memread  = id_memread_i;
            ex_d.ctl.dst      = SLOT_AW'(id_dst_i);
            ex_d.use_rs       = id_use_rs_i;
            ex_d.use_rt       = id_use_rt_i;
            ex_d.rs           = id_rs_w;
            ex_d.rt           = id_rt_w;
        end
        mem_d = ex_q.ctl;
        if (br_w && (BR_STAGE == 3)) begin
            mem_d = '0;
        end
        wb_d = mem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_o),
        .count (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_w),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_mips_hazard_unit.sv
// tb/tb_mips_hazard_unit.sv - self-checking bench for mips_hazard_unit (BR_STAGE 2 and 3, CNT_W 4)
module tb_mips_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic       br_taken;

    // index 0: BR_STAGE=2, index 1: BR_STAGE=3
    logic [1:0] fwd_a[2];
    logic [1:0] fwd_b[2];
    logic       byp_a[2];
    logic       byp_b[2];
    logic       stall[2];
    logic [2:0] flush[2];
    logic [3:0] scnt[2];
    logic [3:0] fcnt[2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_hazard_unit #(.AW(5), .BR_STAGE(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dst_i(id_dst),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .br_taken_i(br_taken),
        .fwd_a_o(fwd_a[0]), .fwd_b_o(fwd_b[0]), .id_byp_a_o(byp_a[0]), .id_byp_b_o(byp_b[0]),
        .stall_o(stall[0]), .flush_o(flush[0]), .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0])
    );

    mips_hazard_unit #(.AW(5), .BR_STAGE(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dst_i(id_dst),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .br_taken_i(br_taken),
        .fwd_a_o(fwd_a[1]), .fwd_b_o(fwd_b[1]), .id_byp_a_o(byp_a[1]), .id_byp_b_o(byp_b[1]),
        .stall_o(stall[1]), .flush_o(flush[1]), .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1])
    );

    // Reference model: the instruction occupying each later stage, per DUT.
    typedef struct {
        bit v;
        int dst;
        bit rw;
        bit mr;
        int rs;
        int rt;
        bit urs;
        bit urt;
    } ins_t;

    ins_t m_ex[2];
    ins_t m_mem[2];
    ins_t m_wb[2];
    int   m_sc[2];
    int   m_fc[2];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic ins_t bubble();
        ins_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic bit writes(ins_t i, int r);
        return i.v && i.rw && r != 0 && i.dst == r;
    endfunction

    function automatic int exp_fwd(int k, bit use_src, int src);
        if (use_src && writes(m_mem[k], src)) return 2;
        if (use_src && writes(m_wb[k], src)) return 1;
        return 0;
    endfunction

    function automatic bit exp_load_use(int k);
        ins_t e;
        e = m_ex[k];
        return e.v && e.mr && e.rw && e.dst != 0 && id_valid &&
               ((id_use_rs && e.dst == int'(id_rs)) || (id_use_rt && e.dst == int'(id_rt)));
    endfunction

    function automatic int sat_inc(int c, bit inc);
        return (inc && c < 15) ? c + 1 : c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = bubble(); m_mem[k] = bubble(); m_wb[k] = bubble();
            m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    // Drive one ID instruction, then compare every output of both DUTs at the falling edge.
    task automatic cyc(input bit v, input int s, input int t, input bit us, input bit ut,
                       input int d, input bit w, input bit m, input bit b);
        id_valid = v; id_rs = 5'(s); id_rt = 5'(t); id_use_rs = us; id_use_rt = ut;
        id_dst = 5'(d); id_regwrite = w; id_memread = m; br_taken = b;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            string sfx;
            int    exp_flush;
            sfx = $sformatf("[br%0d]", k + 2);
            exp_flush = br_taken ? ((k == 1) ? 7 : 3) : 0;
            check({"fwd_a", sfx}, int'(fwd_a[k]), exp_fwd(k, m_ex[k].urs, m_ex[k].rs));
            check({"fwd_b", sfx}, int'(fwd_b[k]), exp_fwd(k, m_ex[k].urt, m_ex[k].rt));
            check({"byp_a", sfx}, int'(byp_a[k]),
                  int'(id_valid && id_use_rs && writes(m_wb[k], int'(id_rs))));
            check({"byp_b", sfx}, int'(byp_b[k]),
                  int'(id_valid && id_use_rt && writes(m_wb[k], int'(id_rt))));
            check({"stall", sfx}, int'(stall[k]), int'(exp_load_use(k) && !br_taken));
            check({"flush", sfx}, int'(flush[k]), exp_flush);
            check({"stall_cnt", sfx}, int'(scnt[k]), m_sc[k]);
            check({"flush_cnt", sfx}, int'(fcnt[k]), m_fc[k]);
        end
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic adv();
        for (int k = 0; k < 2; k++) begin
            bit   lu;
            ins_t nx;
            lu = exp_load_use(k);
            nx = bubble();
            if (id_valid && !br_taken && !lu) begin
                nx.v = 1; nx.dst = int'(id_dst); nx.rw = id_regwrite; nx.mr = id_memread;
                nx.rs = int'(id_rs); nx.rt = int'(id_rt); nx.urs = id_use_rs; nx.urt = id_use_rt;
            end
            m_sc[k]  = sat_inc(m_sc[k], lu && !br_taken);
            m_fc[k]  = sat_inc(m_fc[k], br_taken);
            m_wb[k]  = m_mem[k];
            m_mem[k] = (br_taken && k == 1) ? bubble() : m_ex[k];
            m_ex[k]  = nx;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
        id_use_rs = 0; id_use_rt = 0; id_regwrite = 0; id_memread = 0; br_taken = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_fwd_a", int'(fwd_a[k]), 0);
            check("rst_stall", int'(stall[k]), 0);
            check("rst_flush", int'(flush[k]), 0);
            check("rst_cnt", int'(scnt[k]) + int'(fcnt[k]), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // back-to-back dependency: add $3<-$1,$2 ; sub $4<-$3,$5
        cyc(1, 1, 2, 1, 1, 3, 1, 0, 0); adv();
        cyc(1, 3, 5, 1, 1, 4, 1, 0, 0); adv();
        nop(); check("b2b_fwd_a", int'(fwd_a[1]), 2); check("b2b_stall", int'(stall[1]), 0); adv();
        // same with one NOP between
        cyc(1, 1, 2, 1, 1, 3, 1, 0, 0); adv();
        nop(); adv();
        cyc(1, 3, 5, 1, 1, 4, 1, 0, 0); adv();
        nop(); check("gap_fwd_a", int'(fwd_a[1]), 1); adv();

        // load-use: lw $8 ; add $9<-$8,$8
        cyc(1, 1, 0, 1, 0, 8, 1, 1, 0); adv();
        cyc(1, 8, 8, 1, 1, 9, 1, 0, 0); check("lu_stall", int'(stall[1]), 1); adv();
        cyc(1, 8, 8, 1, 1, 9, 1, 0, 0); check("lu_stall_once", int'(stall[1]), 0);
        check("lu_cnt", int'(scnt[1]), 1); adv();
        nop(); check("lu_fwd_a", int'(fwd_a[1]), 1); check("lu_fwd_b", int'(fwd_b[1]), 1); adv();

        // writer to $0 never forwards nor stalls
        cyc(1, 1, 0, 1, 0, 0, 1, 1, 0); adv();
        cyc(1, 0, 0, 1, 1, 5, 1, 0, 0); check("r0_stall", int'(stall[1]), 0); adv();
        nop(); check("r0_fwd_a", int'(fwd_a[1]), 0); check("r0_fwd_b", int'(fwd_b[1]), 0); adv();

        // MEM and WB both write $3: MEM wins
        cyc(1, 1, 2, 1, 1, 3, 1, 0, 0); adv();
        cyc(1, 1, 2, 1, 1, 3, 1, 0, 0); adv();
        cyc(1, 3, 0, 1, 0, 6, 1, 0, 0); adv();
        nop(); check("prio_fwd_a", int'(fwd_a[1]), 2); adv();

        // branch flush with squashed writers of $3
        cyc(1, 1, 2, 1, 1, 0, 0, 0, 0); adv();
        cyc(1, 1, 2, 1, 1, 3, 1, 0, 0); adv();
        cyc(1, 1, 2, 1, 1, 3, 1, 0, 1);
        check("br_flush3", int'(flush[1]), 7); check("br_flush2", int'(flush[0]), 3); adv();
        cyc(1, 3, 3, 1, 1, 7, 1, 0, 0); check("br_cnt", int'(fcnt[1]), 1);
        check("br_flush_end", int'(flush[1]), 0); adv();
        nop(); check("br_sq_fwd_a", int'(fwd_a[1]), 0); check("br_sq_fwd_b", int'(fwd_b[1]), 0); adv();

        // simultaneous branch and load-use
        cyc(1, 1, 0, 1, 0, 8, 1, 1, 0); adv();
        cyc(1, 8, 0, 1, 0, 9, 1, 0, 1);
        check("both_stall", int'(stall[1]), 0); check("both_flush", int'(flush[1]), 7); adv();
        nop(); check("both_scnt", int'(scnt[1]), 1); check("both_fcnt", int'(fcnt[1]), 2); adv();

        // reset mid-stall / mid-flush
        cyc(1, 1, 0, 1, 0, 8, 1, 1, 0); adv();
        cyc(1, 8, 0, 1, 0, 9, 1, 0, 0); check("mid_stall_pre", int'(stall[1]), 1);
        br_taken = 1'b1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("mid_rst_stall", int'(stall[k]), 0);
            check("mid_rst_flush", int'(flush[k]), 0);
            check("mid_rst_fwd", int'(fwd_a[k]) + int'(fwd_b[k]), 0);
            check("mid_rst_byp", int'(byp_a[k]) + int'(byp_b[k]), 0);
            check("mid_rst_cnt", int'(scnt[k]) + int'(fcnt[k]), 0);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        br_taken = 1'b0;

        // stall counter saturation at 15
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 1, 0, 8, 1, 1, 0); adv();
            cyc(1, 8, 8, 1, 1, 9, 1, 0, 0); adv();
            cyc(1, 8, 8, 1, 1, 9, 1, 0, 0); adv();
        end
        nop(); check("sat_scnt", int'(scnt[1]), 15); check("sat_scnt2", int'(scnt[0]), 15); adv();

        // randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
